// File: rtl/ps2_key_ctrl.sv
// Keyboard-event controller behind the PS/2 frame receiver: edge-detects bytes and errors,
// folds E0/F0 prefixes into make/break events and queues them in a show-ahead FIFO.
module ps2_key_ctrl #(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 50000,
    parameter int TO_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxData,
    input  logic       rxReady,
    input  logic       rxError,
    output logic       rxReset,
    output logic       evValid,
    output logic [7:0] evCode,
    output logic       evBreak,
    output logic       evExt,
    input  logic       evPop,
    output logic       overflow,
    output logic [7:0] errCount
);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [TO_BITS-1:0] TO_LAST  = TO_BITS'(TIMEOUT - 1);

    state_t               state, state_nx;
    logic                 prev_ready, prev_error;
    logic [TO_BITS-1:0]   to_cnt;
    logic [9:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 err_strobe, byte_strobe, overrun, full;
    logic                 push, do_push, do_pop, count_err;
    logic [9:0]           push_data, head;

    // An error edge masks any byte edge in the same cycle.
    assign err_strobe  = rxError & ~prev_error;
    assign byte_strobe = rxReady & ~prev_ready & ~err_strobe;
    assign overrun     = (rxData == 8'h00) || (rxData == 8'hFF);
    assign count_err   = err_strobe || (byte_strobe && overrun);

    assign full    = (count == FULL_CNT);
    assign do_pop  = evPop && (count != '0);
    assign do_push = push && (!full || do_pop);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx  = state;
        push      = 1'b0;
        push_data = {2'b00, rxData};
        if (err_strobe) begin
            state_nx = S_IDLE;
        end else if (byte_strobe) begin
            if (overrun) begin
                state_nx = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rxData == 8'hE0)      state_nx = S_E0;
                        else if (rxData == 8'hF0) state_nx = S_F0;
                        else begin push = 1'b1; push_data = {2'b00, rxData}; end
                    end
                    S_E0: begin
                        if (rxData == 8'hF0)      state_nx = S_E0F0;
                        else if (rxData != 8'hE0) begin
                            push = 1'b1; push_data = {2'b10, rxData}; state_nx = S_IDLE;
                        end
                    end
                    S_F0: begin
                        if (rxData == 8'hE0)      state_nx = S_E0F0;
                        else if (rxData != 8'hF0) begin
                            push = 1'b1; push_data = {2'b01, rxData}; state_nx = S_IDLE;
                        end
                    end
                    S_E0F0: begin
                        if (rxData != 8'hE0 && rxData != 8'hF0) begin
                            push = 1'b1; push_data = {2'b11, rxData}; state_nx = S_IDLE;
                        end
                    end
                    default: state_nx = S_IDLE;
                endcase
            end
        end else if (state != S_IDLE && to_cnt == TO_LAST) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            prev_ready <= 1'b1;
            prev_error <= 1'b1;
            to_cnt     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rxReset    <= 1'b0;
            overflow   <= 1'b0;
            errCount   <= 8'h00;
        end else begin
            state      <= state_nx;
            prev_ready <= rxReady;
            prev_error <= rxError;
            rxReset    <= err_strobe;
            to_cnt     <= (byte_strobe || state == S_IDLE) ? '0 : to_cnt + TO_BITS'(1);
            if (count_err && errCount != 8'hFF) errCount <= errCount + 8'd1;
            if (push && full && !do_pop)        overflow <= 1'b1;
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the event array is deliberately not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head    = (count != '0) ? mem[rd_ptr] : '0;
    assign evValid = (count != '0);
    assign {evExt, evBreak, evCode} = head;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a prefix-flag reference model predicts events into a queue
// that a separate monitor pops and compares as the DUT presents them.
module tb_ps2_key_ctrl;

    localparam int FIFO_AW = 3;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 20;
    localparam int TO_BITS = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxData;
    logic       rxReady, rxError, evPop;
    logic       rxReset, evValid, evBreak, evExt, overflow;
    logic [7:0] evCode, errCount;

    ps2_key_ctrl #(.FIFO_AW(FIFO_AW), .TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)) dut (
        .clk(clk), .reset(reset), .rxData(rxData), .rxReady(rxReady), .rxError(rxError),
        .rxReset(rxReset), .evValid(evValid), .evCode(evCode), .evBreak(evBreak),
        .evExt(evExt), .evPop(evPop), .overflow(overflow), .errCount(errCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    bit         pop_en = 1'b0;
    int         pops_requested = 0;
    int         pops_done = 0;

    // Reference model: accumulated prefix flags plus the cycle of the last prefix byte.
    bit m_ext, m_brk, m_pref;
    int m_last;
    int err_exp;
    bit ovf_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear_prefix();
        m_ext = 1'b0; m_brk = 1'b0; m_pref = 1'b0;
    endtask

    task automatic model_error();
        if (err_exp < 255) err_exp++;
        model_clear_prefix();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit with_pop);
        if (m_pref && (cyc - m_last) > TIMEOUT) model_clear_prefix();
        if (b == 8'h00 || b == 8'hFF) begin
            model_error();
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (b == 8'hE0) m_ext = 1'b1; else m_brk = 1'b1;
            m_pref = 1'b1;
            m_last = cyc;
        end else begin
            if (exp_q.size() < DEPTH || with_pop) exp_q.push_back({m_ext, m_brk, b});
            else ovf_exp = 1'b1;
            model_clear_prefix();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_pop, input int gap, input int hold);
        @(negedge clk);
        if (with_pop) pops_requested++;
        rxData  = b;
        rxReady = 1'b1;
        model_byte(b, with_pop);
        repeat (hold) @(negedge clk);
        rxReady = 1'b0;
        repeat (gap - hold - 1) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b0, 6, 2);
    endtask

    task automatic send_error(input bit verify);
        @(negedge clk);
        rxError = 1'b1;
        model_error();
        @(negedge clk);
        if (verify) check("rxreset_pulse", 32'(rxReset), 32'd1);
        rxError = 1'b0;
        if (verify) begin
            @(negedge clk);
            check("rxreset_one_cycle", 32'(rxReset), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        err_exp = 0;
        ovf_exp = 1'b0;
        model_clear_prefix();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && (exp_q.size() != 0 || evValid); i++) @(negedge clk);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_empty"}, 32'(evValid), 32'd0);
    endtask

    // Monitor: pops whenever enabled or explicitly requested, comparing the head first.
    initial begin
        evPop = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            evPop = 1'b0;
            if (evValid && (pop_en || pops_done < pops_requested)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %0h, expected no event", {evExt, evBreak, evCode});
                end else begin
                    check("event", 32'({evExt, evBreak, evCode}), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                evPop = 1'b1;
                if (pops_done < pops_requested) pops_done++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int gap, r;

        reset = 1'b1; rxData = 8'h00; rxReady = 1'b1; rxError = 1'b1;
        err_exp = 0; ovf_exp = 1'b0; m_last = 0;
        model_clear_prefix();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        // Levels held high across reset must not produce byte or error edges.
        check("rst_evValid", 32'(evValid), 32'd0);
        check("rst_rxReset", 32'(rxReset), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_errCount", 32'(errCount), 32'd0);
        check("rst_head", 32'({evExt, evBreak, evCode}), 32'd0);
        rxReady = 1'b0; rxError = 1'b0;
        repeat (2) @(negedge clk);

        rxData = 8'h1C; rxReady = 1'b1;
        model_byte(8'h1C, 1'b0);
        @(negedge clk);
        check("latency_valid", 32'(evValid), 32'd1);
        check("latency_head", 32'({evExt, evBreak, evCode}), 32'h01C);
        rxReady = 1'b0;
        pops_requested++;
        repeat (2) @(negedge clk);
        check("pop_to_empty", 32'(evValid), 32'd0);

        pop_en = 1'b1;
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h6B);
        wait_drain("prefix");

        send_byte(8'hE0, 1'b0, TIMEOUT + 5, 2); send(8'h1C);
        send_byte(8'hE0, 1'b0, TIMEOUT - 4, 2); send(8'h6B);
        wait_drain("timeout");

        send(8'hF0);
        send_error(1'b1);
        check("err_count_one", 32'(errCount), 32'(err_exp));
        send(8'h1C);
        wait_drain("error");

        send(8'hFF);
        check("overrun_count", 32'(errCount), 32'(err_exp));
        send(8'hE0); send(8'h00); send(8'h1C);
        wait_drain("overrun");
        check("overrun_count2", 32'(errCount), 32'(err_exp));

        pop_en = 1'b0;
        send(8'h11); send(8'h22); send(8'h33);
        do_reset();
        @(negedge clk);
        check("midreset_empty", 32'(evValid), 32'd0);
        check("midreset_errCount", 32'(errCount), 32'd0);

        for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i));
        check("full_no_overflow", 32'(overflow), 32'(ovf_exp));
        send_byte(8'h5A, 1'b1, 6, 2);
        check("pushpop_full_no_overflow", 32'(overflow), 32'(ovf_exp));
        send(8'h66);
        check("overflow_set", 32'(overflow), 32'(ovf_exp));
        pop_en = 1'b1;
        wait_drain("overflow");
        check("overflow_sticky", 32'(overflow), 32'd1);

        do_reset();
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 2) begin
                send_error(1'b1);
            end else begin
                r = int'($urandom_range(0, 9));
                if (r < 2)       b = 8'hE0;
                else if (r == 2) b = 8'hF0;
                else if (r == 3) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                else begin
                    b = 8'($urandom_range(1, 254));
                    if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
                end
                gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT + 3, TIMEOUT + 8))
                                                   : int'($urandom_range(3, 8));
                send_byte(b, 1'b0, gap, int'($urandom_range(1, gap - 1)));
            end
        end
        wait_drain("random");
        check("random_errCount", 32'(errCount), 32'(err_exp));
        check("random_overflow", 32'(overflow), 32'(ovf_exp));

        for (int i = 0; i < 300; i++) send_error(1'b0);
        repeat (2) @(negedge clk);
        check("errCount_saturated", 32'(errCount), 32'(err_exp));
        send(8'hFF);
        check("errCount_stays_sat", 32'(errCount), 32'hFF);
        wait_drain("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
